fetch_buffer: RTL

Dual-issue instruction fetch stage. It sits between the 64-bit instruction memory and the core's decode stage. It generates line addresses, absorbs the memory's one-cycle read latency and stalls, and buffers fetched instructions with their PCs in a circular queue. It presents the two oldest instructions to decode each cycle and flushes on redirect.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/inst_queue2.sv | 68 ++++++
 rtl/fetch_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned LINE_W  = 64;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  // One buffered instruction together with its byte PC.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue2.sv
// Dual-write, dual-read circular buffer of fetch entries.
// Writes and pops of 0..2 entries per cycle; the caller never exceeds capacity or occupancy.
module inst_queue2
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [1:0]             wr_cnt_i,
  input  fetch_entry_t           wr0_i,
  input  fetch_entry_t           wr1_i,
  input  logic [1:0]             pop_cnt_i,
  output fetch_entry_t           head0_o,
  output fetch_entry_t           head1_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [PtrW:0]   count_q, count_d;

  // Pointer and occupancy update; flush empties the queue outright.
  always_comb begin
    head_d  = head_q + PtrW'(pop_cnt_i);
    tail_d  = tail_q + PtrW'(wr_cnt_i);
    count_d = count_q + (PtrW + 1)'(wr_cnt_i) - (PtrW + 1)'(pop_cnt_i);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only observed through valid slots, so no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      if (wr_cnt_i != 2'd0) mem_q[tail_q] <= wr0_i;
      if (wr_cnt_i == 2'd2) mem_q[tail_q + PtrW'(1)] <= wr1_i;
    end
  end

  assign head0_o = mem_q[head_q];
  assign head1_o = mem_q[head_q + PtrW'(1)];
  assign count_o = count_q;

  // The fetch credit scheme must never let the queue overflow.
  overflow_a: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
                               count_d <= (PtrW + 1)'(Depth));

endmodule

// File: rtl/fetch_buffer.sv
// Dual-issue fetch stage: line address generation, one-cycle memory latency absorption,
// instruction queue and redirect flush.
// Optional same-cycle bypass of responses into an empty queue: define FETCH_BUF_BYPASS_EN.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  output logic [ADDR_W-1:0]      addr_o,
  output logic                   req_o,
  input  logic                   mem_stall_i,
  input  logic [LINE_W-1:0]      data_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic [INSTR_W-1:0]     inst0_o,
  output logic [31:0]            inst0_pc_o,
  output logic                   inst0_valid_o,
  output logic [INSTR_W-1:0]     inst1_o,
  output logic [31:0]            inst1_pc_o,
  output logic                   inst1_valid_o,
  input  logic [1:0]             consume_i,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW:0] DepthL = (CntW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   line_pc_q, line_pc_d;
  logic          pending_q, pending_d;
  logic          drop_first_q, drop_first_d;

  logic [31:0]   line_base;
  logic [CntW:0] in_use;
  logic          accept;
  logic          resp_v;
  logic          bypass;
  logic [1:0]    resp_n, view_n, cons_req, consumed, wr_n, pop_n;
  fetch_entry_t  e_lo, e_hi, r0, r1, view0, view1, wr0, wr1;
  fetch_entry_t  q_head0, q_head1;
  logic [CntW-1:0] q_count;

  assign line_base = fetch_pc_q & 32'hFFFF_FFF8;
  assign addr_o    = fetch_pc_q[ADDR_W+2:3];

  // Credit counts queued entries plus two slots reserved for an outstanding line.
  assign in_use = {1'b0, q_count} + (pending_q ? (CntW + 1)'(2) : '0);
  assign req_o  = !reset_i && !redirect_i && ((in_use + (CntW + 1)'(2)) <= DepthL);
  assign accept = req_o && !mem_stall_i;

  // Response decode: line split into entries, lower one dropped after a PC[2]=1 target.
  always_comb begin
    e_lo.pc    = line_pc_q;
    e_lo.instr = data_i[31:0];
    e_hi.pc    = line_pc_q + 32'd4;
    e_hi.instr = data_i[63:32];
    resp_v     = pending_q && !redirect_i && !reset_i;
    r0         = drop_first_q ? e_hi : e_lo;
    r1         = e_hi;
    resp_n     = resp_v ? (drop_first_q ? 2'd1 : 2'd2) : 2'd0;
  end

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = resp_v && (q_count == '0);
`else
  assign bypass = 1'b0;
`endif

  // Decode view, consume clipping and queue write/pop selection.
  always_comb begin
    if (bypass) begin
      view_n = resp_n;
      view0  = r0;
      view1  = r1;
    end else begin
      view_n = (q_count >= CntW'(2)) ? 2'd2 : q_count[1:0];
      view0  = q_head0;
      view1  = q_head1;
    end
    if (reset_i) view_n = 2'd0;

    cons_req = (consume_i == 2'd3) ? 2'd2 : consume_i;
    consumed = (cons_req < view_n) ? cons_req : view_n;
    if (redirect_i || reset_i) consumed = 2'd0;

    wr0   = r0;
    wr1   = r1;
    wr_n  = resp_n;
    pop_n = consumed;
    if (bypass) begin
      // Bypassed entries never enter the queue unless decode leaves them behind.
      pop_n = 2'd0;
      wr_n  = resp_n - consumed;
      if (consumed == 2'd1) wr0 = r1;
    end
  end

  assign inst0_valid_o = (view_n != 2'd0);
  assign inst1_valid_o = (view_n == 2'd2);
  assign inst0_o       = inst0_valid_o ? view0.instr : NOP_INSTR;
  assign inst0_pc_o    = inst0_valid_o ? view0.pc : 32'd0;
  assign inst1_o       = inst1_valid_o ? view1.instr : NOP_INSTR;
  assign inst1_pc_o    = inst1_valid_o ? view1.pc : 32'd0;
  assign count_o       = q_count;

  // Fetch PC, outstanding-line and drop-first next state.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    line_pc_d    = line_pc_q;
    pending_d    = 1'b0;
    drop_first_d = drop_first_q;
    if (redirect_i) begin
      fetch_pc_d   = redirect_pc_i;
      drop_first_d = redirect_pc_i[2];
    end else begin
      if (accept) begin
        line_pc_d  = line_base;
        fetch_pc_d = line_base + 32'd8;
        pending_d  = 1'b1;
      end
      if (resp_v) drop_first_d = 1'b0;
    end
  end

  // Fetch control state; reset behaves as a redirect to RESET_PC.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fetch_pc_q   <= RESET_PC;
      line_pc_q    <= '0;
      pending_q    <= 1'b0;
      drop_first_q <= RESET_PC[2];
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      line_pc_q    <= line_pc_d;
      pending_q    <= pending_d;
      drop_first_q <= drop_first_d;
    end
  end

  inst_queue2 #(
    .Depth (DEPTH)
  ) u_queue (
    .clk_i     (clock_i),
    .rst_i     (reset_i),
    .flush_i   (redirect_i),
    .wr_cnt_i  (wr_n),
    .wr0_i     (wr0),
    .wr1_i     (wr1),
    .pop_cnt_i (pop_n),
    .head0_o   (q_head0),
    .head1_o   (q_head1),
    .count_o   (q_count)
  );

endmodule
